// File: rtl/ad_spike_aer_merger_if.sv
// AER output link of the spike merger: 4-phase req/ack with address and payload.
interface ad_spike_aer_merger_if #(
    parameter int NEUR_W = 8
);
    logic              aer_req;
    logic              aer_ack;
    logic [NEUR_W+1:0] aer_addr;
    logic [5:0]        aer_payload;

    modport master (
        output aer_req,
        output aer_addr,
        output aer_payload,
        input  aer_ack
    );

    modport slave (
        input  aer_req,
        input  aer_addr,
        input  aer_payload,
        output aer_ack
    );
endinterface

// File: rtl/ad_spike_aer_merger.sv
// Spike merger: captures the three per-update neuron spike outputs into
// per-channel FIFOs tagged with the neuron index, then serialises them
// round-robin onto a single 4-phase AER link.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no request outstanding; grant next non-empty channel
// S_REQ    | aer_req high, addr/payload held, waiting for aer_ack=1
// S_ACKLO  | granted entry popped, waiting for aer_ack to return to 0
module ad_spike_aer_merger #(
    parameter int FIFO_DEPTH = 4,
    parameter int NEUR_W     = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [NEUR_W-1:0] in_neur_idx,
    input  logic [6:0]        event_out1,
    input  logic [6:0]        event_out2,
    input  logic [6:0]        event_out3,
    output logic              stall,
    output logic [2:0]        overflow,
    input  logic              ovf_clr,
    ad_spike_aer_merger_if.master aer
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = NEUR_W + 6;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACKLO} state_t;

    state_t            state_q, state_d;
    logic [6:0]        ev [3];
    logic [EW-1:0]     mem [3][FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr [3];
    logic [AW-1:0]     rd_ptr [3];
    logic [AW:0]       count [3];
    logic [2:0]        full, empty, push_ok, drop, pop;
    logic [1:0]        rr_q, rr_d, gnt_q, gnt_d, sel;
    logic              sel_vld, load;
    logic [EW-1:0]     head;
    logic [NEUR_W+1:0] addr_q;
    logic [5:0]        pay_q;

    assign ev[0] = event_out1;
    assign ev[1] = event_out2;
    assign ev[2] = event_out3;

    // Fullness is taken from registered counts, so a same-cycle pop never frees a slot for a push.
    always_comb begin
        full    = '0;
        empty   = '0;
        push_ok = '0;
        drop    = '0;
        for (int k = 0; k < 3; k++) begin
            full[k]  = (count[k] == (AW+1)'(FIFO_DEPTH));
            empty[k] = (count[k] == '0);
            if (in_valid && ev[k][6]) begin
                if (full[k]) drop[k]    = 1'b1;
                else         push_ok[k] = 1'b1;
            end
        end
    end

    assign stall = |full;

    // Pick the first non-empty channel at or after the round-robin pointer.
    always_comb begin
        logic [2:0] c;
        c       = '0;
        sel_vld = 1'b0;
        sel     = rr_q;
        for (int i = 2; i >= 0; i--) begin
            c = {1'b0, rr_q} + 3'(i);
            if (c >= 3'd3) c = c - 3'd3;
            if (!empty[c]) begin
                sel_vld = 1'b1;
                sel     = c[1:0];
            end
        end
    end

    // Head entry of the selected channel.
    always_comb begin
        head = '0;
        for (int k = 0; k < 3; k++) begin
            if (sel == 2'(k)) head = mem[k][rd_ptr[k]];
        end
    end

    // Next-state, grant, pop and round-robin update.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        load    = 1'b0;
        pop     = '0;
        case (state_q)
            S_IDLE: begin
                if (sel_vld) begin
                    load    = 1'b1;
                    gnt_d   = sel;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (aer.aer_ack) begin
                    pop     = 3'b001 << gnt_q;
                    rr_d    = (gnt_q == 2'd2) ? 2'd0 : gnt_q + 2'd1;
                    state_d = S_ACKLO;
                end
            end
            S_ACKLO: begin
                if (!aer.aer_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state, grant, round-robin pointer and held link data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'd0;
            rr_q    <= 2'd0;
            addr_q  <= '0;
            pay_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            if (load) begin
                addr_q <= {sel + 2'd1, head[EW-1:6]};
                pay_q  <= head[5:0];
            end
        end
    end

    assign aer.aer_req     = (state_q == S_REQ);
    assign aer.aer_addr    = addr_q;
    assign aer.aer_payload = pay_q;

    // FIFO pointers and occupancy counts.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 3; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (push_ok[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
                if (pop[k])     rd_ptr[k] <= rd_ptr[k] + 1'b1;
                case ({push_ok[k], pop[k]})
                    2'b10:   count[k] <= count[k] + 1'b1;
                    2'b01:   count[k] <= count[k] - 1'b1;
                    default: count[k] <= count[k];
                endcase
            end
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            if (push_ok[k]) mem[k][wr_ptr[k]] <= {in_neur_idx, ev[k][5:0]};
        end
    end

    // Sticky drop flags; a drop in the clearing cycle keeps its flag set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) overflow <= '0;
        else     overflow <= (overflow & ~{3{ovf_clr}}) | drop;
    end
endmodule

// File: tb/tb_ad_spike_aer_merger.sv
// Directed bench for the spike AER merger.
module tb_ad_spike_aer_merger;
    logic       CLK;
    logic       RST;
    logic       in_valid;
    logic [7:0] in_neur_idx;
    logic [6:0] event_out1, event_out2, event_out3;
    logic       stall;
    logic [2:0] overflow;
    logic       ovf_clr;
    int         passed = 0;
    int         total  = 0;

    ad_spike_aer_merger_if #(.NEUR_W(8)) aer ();

    ad_spike_aer_merger #(.FIFO_DEPTH(4), .NEUR_W(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_neur_idx (in_neur_idx),
        .event_out1  (event_out1),
        .event_out2  (event_out2),
        .event_out3  (event_out3),
        .stall       (stall),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .aer         (aer)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] idx, input logic [6:0] e1, input logic [6:0] e2,
                        input logic [6:0] e3);
        in_valid    = 1'b1;
        in_neur_idx = idx;
        event_out1  = e1;
        event_out2  = e2;
        event_out3  = e3;
        tick();
        in_valid    = 1'b0;
        event_out1  = '0;
        event_out2  = '0;
        event_out3  = '0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (aer.aer_req) break;
            tick();
        end
        check("req_wait", 32'(aer.aer_req), 32'd1);
    endtask

    task automatic handshake(input string tag, input logic [9:0] exp_addr, input logic [5:0] exp_pay);
        wait_req();
        check({tag, "_addr"}, 32'(aer.aer_addr), 32'(exp_addr));
        check({tag, "_pay"}, 32'(aer.aer_payload), 32'(exp_pay));
        aer.aer_ack = 1'b1;
        tick();
        check({tag, "_reqlo"}, 32'(aer.aer_req), 32'd0);
        aer.aer_ack = 1'b0;
        tick();
    endtask

    initial begin
        RST         = 1'b1;
        in_valid    = 1'b0;
        in_neur_idx = '0;
        event_out1  = '0;
        event_out2  = '0;
        event_out3  = '0;
        ovf_clr     = 1'b0;
        aer.aer_ack = 1'b0;
        repeat (2) tick();

        // reset values
        check("rst_req", 32'(aer.aer_req), 32'd0);
        check("rst_addr", 32'(aer.aer_addr), 32'd0);
        check("rst_pay", 32'(aer.aer_payload), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        RST = 1'b0;
        tick();

        // triple event: ch1, ch2, ch3 in order
        push(8'h10, 7'h41, 7'h42, 7'h43);
        handshake("tri1", 10'h110, 6'h01);
        handshake("tri2", 10'h210, 6'h02);
        handshake("tri3", 10'h310, 6'h03);

        // single event on ch2 with latency check
        push(8'h2A, 7'h00, 7'h45, 7'h00);
        check("single_lat0", 32'(aer.aer_req), 32'd0);
        tick();
        check("single_lat1", 32'(aer.aer_req), 32'd1);
        handshake("single", 10'h22A, 6'h05);
        repeat (3) tick();
        check("single_empty", 32'(aer.aer_req), 32'd0);

        // round robin: grant ch1, then ch1+ch3 pending -> ch3 first
        push(8'h01, 7'h4A, 7'h00, 7'h00);
        handshake("rr_a", 10'h101, 6'h0A);
        push(8'h02, 7'h4B, 7'h00, 7'h4C);
        handshake("rr_b", 10'h302, 6'h0C);
        handshake("rr_c", 10'h102, 6'h0B);

        // overflow: ack held low, five ch1 pushes
        for (int i = 1; i <= 4; i++) begin
            push(8'h80 + 8'(i), 7'h40 | 7'(i), 7'h00, 7'h00);
            if (i == 3) check("ovf_stall3", 32'(stall), 32'd0);
        end
        check("ovf_stall4", 32'(stall), 32'd1);
        check("ovf_none", 32'(overflow), 32'd0);
        push(8'h85, 7'h45, 7'h00, 7'h00);
        check("ovf_set", 32'(overflow), 32'b001);
        check("ovf_stall5", 32'(stall), 32'd1);
        ovf_clr = 1'b1;
        push(8'h86, 7'h46, 7'h00, 7'h00);
        check("ovf_setwins", 32'(overflow), 32'b001);
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            handshake("ovf_drain", {2'b01, 8'h80 + 8'(i)}, 6'(i));
        end
        repeat (3) tick();
        check("ovf_after_req", 32'(aer.aer_req), 32'd0);
        check("ovf_after_stall", 32'(stall), 32'd0);

        // async reset mid-handshake with three buffered entries
        push(8'h20, 7'h41, 7'h42, 7'h43);
        tick();
        check("arst_req_pre", 32'(aer.aer_req), 32'd1);
        RST = 1'b1;
        #1;
        check("arst_req", 32'(aer.aer_req), 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_addr", 32'(aer.aer_addr), 32'd0);
        #1;
        RST = 1'b0;
        repeat (5) tick();
        check("arst_noreq", 32'(aer.aer_req), 32'd0);
        push(8'h55, 7'h00, 7'h00, 7'h7F);
        handshake("arst_new", 10'h355, 6'h3F);

        // spike bits clear: nothing pushed
        push(8'h77, 7'h05, 7'h3F, 7'h00);
        repeat (4) tick();
        check("nospike_req", 32'(aer.aer_req), 32'd0);
        check("nospike_stall", 32'(stall), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
